// File: rtl/block_tx_serializer.sv
// rtl/block_tx_serializer.sv - streams one NBYTES-wide result block, byte by byte, into a UART transmitter
module block_tx_serializer #(
    parameter int NBYTES    = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_blk_valid,
    input  logic [8*NBYTES-1:0] i_blk_data,
    output logic                o_blk_ready,
    output logic                o_tx_start,
    output logic [7:0]          o_tx_data,
    input  logic                i_tx_busy,
    output logic                o_busy,
    output logic                o_done
);

    localparam int            W        = 8 * NBYTES;
    localparam int            IW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [W-1:0]  r_shift;
    logic [IW-1:0] r_idx;
    logic          r_tx_start;
    logic [7:0]    r_tx_data;
    logic          r_done;
    logic [7:0]    w_cur_byte;
    logic [W-1:0]  w_shift_next;
    logic          w_last;

    // The byte on the send end of the shift register is always the next one out.
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_cur_byte   = r_shift[7:0];
            assign w_shift_next = r_shift >> 8;
        end else begin : g_msb_first
            assign w_cur_byte   = r_shift[W-1 -: 8];
            assign w_shift_next = r_shift << 8;
        end
    endgenerate

    assign w_last = (r_idx == LAST_IDX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_blk_valid) w_next = S_SEND;
            S_SEND:    if (!i_tx_busy) w_next = S_WAIT_HI;
            S_WAIT_HI: if (i_tx_busy) w_next = S_WAIT_LO;
            S_WAIT_LO: if (!i_tx_busy) w_next = w_last ? S_IDLE : S_SEND;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift    <= '0;
            r_idx      <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_done     <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_blk_valid) begin
                        r_shift <= i_blk_data;
                        r_idx   <= '0;
                    end
                end
                S_SEND: begin
                    if (!i_tx_busy) begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= w_cur_byte;
                    end
                end
                S_WAIT_LO: begin
                    if (!i_tx_busy) begin
                        if (w_last) begin
                            r_done <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_shift <= w_shift_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_blk_ready = (r_state == S_IDLE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_tx_start  = r_tx_start;
    assign o_tx_data   = r_tx_data;
    assign o_done      = r_done;

endmodule
